// File: rtl/lap_display_ctrl_pkg.sv
// Shared widths, display-mode encodings and control FSM state codes for the
// stopwatch lap/split display path, so every block agrees on them.
package lap_display_ctrl_pkg;

    localparam int TIME_W     = 14;  // {min[7:0], sec[5:0]}
    localparam int LAP_DEPTH  = 4;   // power of 2
    localparam int HOLD_TICKS = 3;   // seconds a captured split stays frozen

    localparam int IDX_W  = $clog2(LAP_DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    // What the display is showing; this is also the lap/display FSM state.
    typedef enum logic [1:0] {
        DISP_LIVE   = 2'b00,
        DISP_HOLD   = 2'b01,
        DISP_REVIEW = 2'b10
    } disp_mode_e;

    // State codes of the upstream run/pause control FSM.
    typedef enum logic [1:0] {
        CTRL_IDLE    = 2'b00,
        CTRL_RUNNING = 2'b01,
        CTRL_PAUSED  = 2'b10
    } ctrl_state_e;

    typedef logic [TIME_W-1:0] time_t;

endpackage

// File: rtl/lap_display_ctrl_if.sv
// Signal bundle between the stopwatch control side and the lap/display block.
// There is no valid/ready handshake here: tick_1hz, lap and clear_counters are
// single-cycle pulses acted on in the cycle they are high; count_en and
// live_time are levels sampled every cycle; every output is a registered level
// except lap_dropped, which is a registered single-cycle pulse.
interface lap_display_ctrl_if;
    import lap_display_ctrl_pkg::*;

    logic              tick_1hz;
    logic              count_en;
    logic              clear_counters;
    logic              lap;
    time_t             live_time;

    time_t             disp_time;
    logic [1:0]        disp_mode;
    logic [IDX_W-1:0]  lap_idx;
    logic [CNT_W-1:0]  lap_count;
    logic              buf_full;
    logic              lap_dropped;
    disp_mode_e        state_dbg;

    modport master (
        output tick_1hz, count_en, clear_counters, lap, live_time,
        input  disp_time, disp_mode, lap_idx, lap_count, buf_full, lap_dropped,
        input  state_dbg
    );

    modport slave (
        input  tick_1hz, count_en, clear_counters, lap, live_time,
        output disp_time, disp_mode, lap_idx, lap_count, buf_full, lap_dropped,
        output state_dbg
    );

endinterface

// File: rtl/lap_display_ctrl_lap_buffer.sv
// Lap storage: LAP_DEPTH x TIME_W register file, one synchronous write port,
// one asynchronous read port, cleared by reset.
module lap_display_ctrl_lap_buffer
    import lap_display_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  time_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output time_t            rdata
);

    time_t mem [LAP_DEPTH];

    // Write the addressed entry on a strobe; reset clears every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lap_display_ctrl.sv
// Lap/split sequencer for the stopwatch display: captures laps into the lap
// buffer, freezes a split on screen for HOLD_TICKS seconds, and lets the user
// scroll stored laps while paused.
module lap_display_ctrl
    import lap_display_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    lap_display_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0]  LAP_FULL  = CNT_W'(LAP_DEPTH);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LAP_DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    disp_mode_e        state;
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  lap_idx;
    logic [CNT_W-1:0]  lap_count;
    logic [HOLD_W-1:0] hold_cnt;
    time_t             hold_reg;
    time_t             disp_time;
    logic              buf_full;
    logic              lap_dropped;

    logic              cap_req;
    logic              full_now;
    logic              buf_we;
    logic              idx_last;
    time_t             buf_rdata;
    time_t             disp_src;

    // Capture decision: a running lap captures from any state unless a clear
    // wins the cycle; a full buffer turns the write into a drop.
    always_comb begin
        cap_req  = 1'b0;
        full_now = 1'b0;
        buf_we   = 1'b0;
        idx_last = 1'b0;
        cap_req  = bus.lap & bus.count_en & ~bus.clear_counters;
        full_now = (lap_count == LAP_FULL);
        buf_we   = cap_req & ~full_now;
        idx_last = ({1'b0, lap_idx} == (lap_count - CNT_W'(1)));
    end

    // Display source for the current state; registered one cycle later.
    always_comb begin
        disp_src = bus.live_time;
        unique case (state)
            DISP_LIVE:   disp_src = bus.live_time;
            DISP_HOLD:   disp_src = hold_reg;
            DISP_REVIEW: disp_src = buf_rdata;
            default:     disp_src = bus.live_time;
        endcase
    end

    lap_display_ctrl_lap_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (bus.live_time),
        .raddr (lap_idx),
        .rdata (buf_rdata)
    );

    // Lap/display FSM with its counters and all registered outputs.
    // Priority: clear_counters > lap > tick_1hz > count_en change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DISP_LIVE;
            wr_ptr      <= '0;
            lap_idx     <= '0;
            lap_count   <= '0;
            hold_cnt    <= '0;
            hold_reg    <= '0;
            disp_time   <= '0;
            buf_full    <= 1'b0;
            lap_dropped <= 1'b0;
        end else begin
            disp_time   <= disp_src;
            lap_dropped <= 1'b0;
            if (bus.clear_counters) begin
                state     <= DISP_LIVE;
                wr_ptr    <= '0;
                lap_idx   <= '0;
                lap_count <= '0;
                hold_cnt  <= '0;
                buf_full  <= 1'b0;
            end else if (cap_req) begin
                // Same capture in LIVE, HOLD (reloads the hold, tick lost)
                // and REVIEW (resume plus lap in one cycle).
                if (full_now) begin
                    lap_dropped <= 1'b1;
                end else begin
                    // wr_ptr parks on the last entry instead of wrapping.
                    if (wr_ptr != IDX_LAST) begin
                        wr_ptr <= wr_ptr + IDX_W'(1);
                    end
                    lap_count <= lap_count + CNT_W'(1);
                    buf_full  <= (lap_count == (LAP_FULL - CNT_W'(1)));
                end
                hold_reg <= bus.live_time;
                hold_cnt <= HOLD_LOAD;
                lap_idx  <= '0;
                state    <= DISP_HOLD;
            end else begin
                unique case (state)
                    DISP_LIVE: begin
                        // Paused lap opens review only when laps exist.
                        if (bus.lap && lap_count != '0) begin
                            lap_idx <= '0;
                            state   <= DISP_REVIEW;
                        end
                    end
                    DISP_HOLD: begin
                        // Paused laps are ignored; only the hold timer runs.
                        if (bus.tick_1hz) begin
                            if (hold_cnt == HOLD_W'(1)) begin
                                hold_cnt <= '0;
                                state    <= DISP_LIVE;
                            end else begin
                                hold_cnt <= hold_cnt - HOLD_W'(1);
                            end
                        end
                    end
                    DISP_REVIEW: begin
                        if (bus.lap) begin
                            lap_idx <= idx_last ? '0 : lap_idx + IDX_W'(1);
                        end else if (bus.count_en) begin
                            lap_idx <= '0;
                            state   <= DISP_LIVE;
                        end
                    end
                    default: begin
                        state <= DISP_LIVE;
                    end
                endcase
            end
        end
    end

    assign bus.disp_time   = disp_time;
    assign bus.disp_mode   = state;
    assign bus.state_dbg   = state;
    assign bus.lap_idx     = lap_idx;
    assign bus.lap_count   = lap_count;
    assign bus.buf_full    = buf_full;
    assign bus.lap_dropped = lap_dropped;

endmodule
